// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencer: state encoding and default widths.
package fir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } fir_state_e;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned OUT_W_DEF  = 32;

endpackage

// File: rtl/fir_tag_pipe.sv
// LAT-deep 1-bit shift register carrying "emit" tags alongside the filter latency.
module fir_tag_pipe #(
   parameter int unsigned LAT = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tag_i,
   output logic tag_o
);

   logic [LAT-1:0] sr_q;
   logic [LAT-1:0] sr_d;

   always_comb begin
      sr_d    = '0;
      sr_d[0] = tag_i;
      for (int unsigned i = 1; i < LAT; i++) begin
         sr_d[i] = sr_q[i-1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign tag_o = sr_q[LAT-1];

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for fir_filter: gates pushes into the tap buffer, suppresses warm-up
// results, re-times filter output into an m_valid stream and flushes on stop.
module fir_seq_ctrl
   import fir_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned OUT_W  = OUT_W_DEF,
   parameter int unsigned TAPS   = 8,
   parameter int unsigned LAT    = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     s_valid,
   input  logic signed [DATA_W-1:0] s_data,
   output logic                     s_ready,
   output logic                     buff_en,
   output logic                     fir_en,
   output logic signed [DATA_W-1:0] fir_data,
   input  logic signed [OUT_W-1:0]  fir_filtered_data,
   output logic                     m_valid,
   output logic signed [OUT_W-1:0]  m_data,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned CW = $clog2(TAPS + 1);
   localparam int unsigned FW = $clog2(TAPS + LAT);
   localparam logic [CW-1:0] CNT_EMIT  = CW'(TAPS - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(TAPS);
   localparam logic [FW-1:0] FL_PUSHES = FW'(TAPS - 1);
   localparam logic [FW-1:0] FL_LAST   = FW'(TAPS + LAT - 1);

   fir_state_e               state_q, state_d;
   logic [CW-1:0]            push_cnt_q, push_cnt_d;
   logic [FW-1:0]            flush_cnt_q, flush_cnt_d;
   logic                     push, emit, done_d;
   logic signed [DATA_W-1:0] push_data;
   logic                     push_q, emit_q, done_q, m_valid_q, tag_out;
   logic signed [DATA_W-1:0] fir_data_q;
   logic signed [OUT_W-1:0]  m_data_q;

   assign s_ready = (state_q == ST_FILL) || (state_q == ST_RUN);
   assign busy    = (state_q != ST_IDLE);

   always_comb begin
      state_d     = state_q;
      push_cnt_d  = push_cnt_q;
      flush_cnt_d = flush_cnt_q;
      push        = 1'b0;
      push_data   = '0;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_FILL;
               push_cnt_d = '0;
            end
         end
         ST_FILL, ST_RUN: begin
            push      = s_valid;
            push_data = s_data;
            if (stop) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = '0;
            end else if (state_q == ST_FILL && s_valid && push_cnt_q == CNT_EMIT) begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            push = (flush_cnt_q < FL_PUSHES);
            if (flush_cnt_q == FL_LAST) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      emit = push && (push_cnt_q >= CNT_EMIT);
      if (push && push_cnt_q != CNT_FULL) begin
         push_cnt_d = push_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         push_cnt_q  <= '0;
         flush_cnt_q <= '0;
         push_q      <= 1'b0;
         emit_q      <= 1'b0;
         fir_data_q  <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         push_cnt_q  <= push_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         push_q      <= push;
         emit_q      <= emit;
         done_q      <= done_d;
         m_valid_q   <= tag_out;
         if (push) begin
            fir_data_q <= push_data;
         end
         if (tag_out) begin
            m_data_q <= fir_filtered_data;
         end
      end
   end

   // emit_q aligns the tag with fir_en; the pipe then adds LAT, so m_valid lands LAT+1 after the push.
   fir_tag_pipe #(.LAT(LAT)) u_tag_pipe (
      .clk_i (clk),
      .rst_i (reset),
      .tag_i (emit_q),
      .tag_o (tag_out)
   );

   assign buff_en  = push_q;
   assign fir_en   = push_q;
   assign fir_data = fir_data_q;
   assign m_valid  = m_valid_q;
   assign m_data   = m_data_q;
   assign done     = done_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl against a cycle-scheduled reference model.
module tb_fir_seq_ctrl;

   localparam int unsigned DW   = 16;
   localparam int unsigned OW   = 32;
   localparam int unsigned TAPS = 8;
   localparam int unsigned LAT  = 2;
   localparam int          MAXC = 4096;

   logic                 clk = 1'b0;
   logic                 reset, start, stop, s_valid;
   logic signed [DW-1:0] s_data;
   logic                 s_ready, buff_en, fir_en, m_valid, busy, done;
   logic signed [DW-1:0] fir_data;
   logic signed [OW-1:0] fir_filtered_data;
   logic signed [OW-1:0] m_data;

   always #5 clk = ~clk;

   fir_seq_ctrl #(.DATA_W(DW), .OUT_W(OW), .TAPS(TAPS), .LAT(LAT)) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .stop              (stop),
      .s_valid           (s_valid),
      .s_data            (s_data),
      .s_ready           (s_ready),
      .buff_en           (buff_en),
      .fir_en            (fir_en),
      .fir_data          (fir_data),
      .fir_filtered_data (fir_filtered_data),
      .m_valid           (m_valid),
      .m_data            (m_data),
      .busy              (busy),
      .done              (done)
   );

   int n_asserts = 0;
   int n_fails   = 0;
   int cyc       = 0;

   // Reference model: mode 0 idle, 1 accepting samples, 2 flushing.
   int                   m_mode;
   int                   pushes;
   int                   flush_e0;
   logic                 exp_mv  [MAXC];
   logic signed [OW-1:0] ffd_log [MAXC];
   logic                 e_ready, e_busy, e_push, e_mv, e_done;
   logic signed [DW-1:0] e_fir_data;
   logic signed [OW-1:0] e_m_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("s_ready",  64'(s_ready),  64'(e_ready));
      chk("busy",     64'(busy),     64'(e_busy));
      chk("buff_en",  64'(buff_en),  64'(e_push));
      chk("fir_en",   64'(fir_en),   64'(e_push));
      chk("fir_data", 64'(fir_data), 64'(e_fir_data));
      chk("m_valid",  64'(m_valid),  64'(e_mv));
      chk("m_data",   64'(m_data),   64'(e_m_data));
      chk("done",     64'(done),     64'(e_done));
   endtask

   task automatic model_clear();
      m_mode     = 0;
      pushes     = 0;
      flush_e0   = 0;
      e_ready    = 1'b0;
      e_busy     = 1'b0;
      e_push     = 1'b0;
      e_mv       = 1'b0;
      e_done     = 1'b0;
      e_fir_data = '0;
      e_m_data   = '0;
      for (int i = 0; i < MAXC; i++) exp_mv[i] = 1'b0;
   endtask

   // Predict outputs visible just after edge e = cyc+1 from the inputs currently applied.
   task automatic model_eval();
      int                   e;
      int                   k;
      logic signed [DW-1:0] pd;
      e      = cyc + 1;
      e_push = 1'b0;
      e_done = 1'b0;
      pd     = '0;
      case (m_mode)
         0: if (start) begin
            m_mode = 1;
            pushes = 0;
         end
         1: begin
            if (s_valid) begin
               e_push = 1'b1;
               pd     = s_data;
            end
            if (stop) begin
               m_mode   = 2;
               flush_e0 = e;
            end
         end
         default: begin
            k = e - flush_e0;
            if (k <= int'(TAPS) - 1) e_push = 1'b1;
            if (k == int'(TAPS + LAT)) begin
               e_done = 1'b1;
               m_mode = 0;
            end
         end
      endcase
      if (e_push) begin
         pushes++;
         e_fir_data = pd;
         if (pushes >= int'(TAPS) && e + int'(LAT) + 1 < MAXC) exp_mv[e + int'(LAT) + 1] = 1'b1;
      end
      e_mv = exp_mv[e];
      if (e_mv) e_m_data = ffd_log[e];
      e_ready = (m_mode == 1);
      e_busy  = (m_mode != 0);
   endtask

   task automatic step(input logic st, input logic sp, input logic sv, input logic signed [DW-1:0] sd);
      start   = st;
      stop    = sp;
      s_valid = sv;
      s_data  = sd;
      fir_filtered_data = OW'($urandom);
      ffd_log[cyc + 1]  = fir_filtered_data;
      model_eval();
      @(posedge clk);
      cyc++;
      #1 check_all();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
   endtask

   task automatic do_reset();
      start   = 1'b0;
      stop    = 1'b0;
      s_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      model_clear();
      check_all();
      @(posedge clk);
      cyc++;
      #1 check_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int len;
      reset   = 1'b1;
      start   = 1'b0;
      stop    = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      fir_filtered_data = '0;
      model_clear();
      #1 check_all();
      @(negedge clk);
      reset = 1'b0;

      // Warm-up: eight back-to-back samples, only the eighth emits.
      step(1'b1, 1'b0, 1'b0, '0);
      repeat (TAPS) step(1'b0, 1'b0, 1'b1, 16'sh1000);
      repeat (4) step(1'b0, 1'b0, 1'b0, DW'($urandom));

      // Gapped valid while running.
      step(1'b0, 1'b0, 1'b1, DW'($urandom));
      step(1'b0, 1'b0, 1'b0, DW'($urandom));
      step(1'b0, 1'b0, 1'b0, DW'($urandom));
      step(1'b0, 1'b0, 1'b1, DW'($urandom));
      repeat (4) step(1'b0, 1'b0, 1'b0, DW'($urandom));

      // Stop from RUN, full flush.
      step(1'b0, 1'b1, 1'b0, '0);
      idle(TAPS + LAT + 2);

      // Stop after three FILL pushes.
      step(1'b1, 1'b0, 1'b0, '0);
      repeat (3) step(1'b0, 1'b0, 1'b1, DW'($urandom));
      step(1'b0, 1'b1, 1'b0, '0);
      idle(TAPS + LAT + 2);

      // Start ignored in RUN; stop coincident with an accepted push.
      step(1'b1, 1'b0, 1'b0, '0);
      repeat (12) step(1'b0, 1'b0, 1'b1, DW'($urandom));
      repeat (5) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
      step(1'b0, 1'b1, 1'b1, DW'($urandom));
      idle(TAPS + LAT + 2);

      // Reset during FLUSH discards pending tags; then a clean restart.
      step(1'b1, 1'b0, 1'b0, '0);
      repeat (10) step(1'b0, 1'b0, 1'b1, DW'($urandom));
      step(1'b0, 1'b1, 1'b0, '0);
      idle(4);
      do_reset();
      idle(6);
      step(1'b1, 1'b0, 1'b0, '0);
      repeat (9) step(1'b0, 1'b0, 1'b1, DW'($urandom));
      step(1'b0, 1'b1, 1'b0, '0);
      idle(TAPS + LAT + 2);

      // Randomized sessions.
      repeat (8) begin
         len = $urandom_range(1, 25);
         step(1'b1, 1'b0, 1'b0, '0);
         repeat (len) step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
         step(1'b0, 1'b1, 1'($urandom_range(0, 1)), DW'($urandom));
         idle(TAPS + LAT + int'($urandom_range(1, 4)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
